dp_ram_be_clr: RTL and testbench

True dual-port synchronous RAM with per-byte write enables and a selectable read-during-write policy. It has an optional output pipeline register, cross-port collision detection and a hardware clear sequencer that fills the array with a constant after reset or on request. It replaces the plain dual-port sync-read RAM wherever buffers need partial-word writes, deterministic post-reset contents or higher clock rates.

---
 rtl/dp_ram_be_clr.sv | 175 +++++++++++++++++
 tb/tb_dp_ram_be_clr.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_be_clr.sv
// True dual-port synchronous RAM with byte write enables, a selectable same-port
// read-during-write policy, an optional output register and a clear sequencer.
module dp_ram_be_clr #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    MEM_DEPTH  = 1024,
    parameter int                    ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int                    RDW_MODE   = 0,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    output logic                             busy,
    input  logic                             en_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            din_a,
    input  logic [DATA_WIDTH-1:0]            din_b,
    output logic [DATA_WIDTH-1:0]            dout_a,
    output logic [DATA_WIDTH-1:0]            dout_b,
    output logic                             valid_a,
    output logic                             valid_b,
    output logic                             collision
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                    w_blk;
    logic [1:0]              w_en, w_in;
    logic [NUM_BYTES-1:0]    w_we   [2];
    logic [ADDR_WIDTH-1:0]   w_addr [2];
    logic [DATA_WIDTH-1:0]   w_din  [2];
    logic [DATA_WIDTH-1:0]   w_rd   [2];
    logic [1:0]              r_v1, w_vo;
    logic [DATA_WIDTH-1:0]   r_d1 [2];
    logic [DATA_WIDTH-1:0]   w_do [2];
    logic                    r_coll;

    assign busy = (r_state == S_CLEAR);

    // Accesses are suppressed during a sweep and on the edge that starts one.
    assign w_blk     = busy | clear | rst;
    assign w_en      = {en_b, en_a} & {2{~w_blk}};
    assign w_we[0]   = we_a;
    assign w_we[1]   = we_b;
    assign w_addr[0] = addr_a;
    assign w_addr[1] = addr_b;
    assign w_din[0]  = din_a;
    assign w_din[1]  = din_b;
    assign w_in[0]   = 32'(addr_a) < MEM_DEPTH;
    assign w_in[1]   = 32'(addr_b) < MEM_DEPTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the array has no reset; deterministic contents come from the clear sweep,
    // which keeps the storage mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_CLEAR)
            r_mem[r_cnt] <= INIT_VALUE;
        // NOTE: port B is written before port A so A's later non-blocking update
        // wins on bytes both ports enable.
        for (int p = 1; p >= 0; p--) begin
            if (w_en[p] && w_in[p]) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (w_we[p][i])
                        r_mem[w_addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Cross-port reads always see the pre-edge word; only a port's own write can merge.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = '0;
            if (w_in[p]) begin
                w_rd[p] = r_mem[w_addr[p]];
                if (RDW_MODE != 0) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (w_we[p][i])
                            w_rd[p][i*BYTE_WIDTH +: BYTE_WIDTH] = w_din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= '0;
            r_coll <= 1'b0;
            for (int p = 0; p < 2; p++) r_d1[p] <= '0;
        end else begin
            r_v1   <= w_en;
            r_coll <= w_en[0] & w_en[1] & (addr_a == addr_b) & (|we_a | |we_b);
            for (int p = 0; p < 2; p++) begin
                if (w_en[p]) r_d1[p] <= w_rd[p];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [1:0]            r_v2;
            logic [DATA_WIDTH-1:0] r_d2 [2];
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2 <= '0;
                    for (int p = 0; p < 2; p++) r_d2[p] <= '0;
                end else begin
                    r_v2 <= r_v1;
                    for (int p = 0; p < 2; p++) begin
                        if (r_v1[p]) r_d2[p] <= r_d1[p];
                    end
                end
            end
            assign w_vo    = r_v2;
            assign w_do[0] = r_d2[0];
            assign w_do[1] = r_d2[1];
        end else begin : g_noreg
            assign w_vo    = r_v1;
            assign w_do[0] = r_d1[0];
            assign w_do[1] = r_d1[1];
        end
    endgenerate

    assign valid_a   = w_vo[0];
    assign valid_b   = w_vo[1];
    assign dout_a    = w_do[0];
    assign dout_b    = w_do[1];
    assign collision = r_coll;

endmodule

// File: tb/tb_dp_ram_be_clr.sv
// Drives two RAM configurations (16 words/old-data/no out reg, 10 words/new-data/out reg)
// with shared directed and random stimulus, comparing both against an array model.
module tb_dp_ram_be_clr;
    localparam int          DEP0 = 16;
    localparam int          DEP1 = 10;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst, clear, en_a, en_b;
    logic [3:0]  we_a, we_b, addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic        busy [2], valid_a [2], valid_b [2], collision [2];
    logic [31:0] dout_a [2], dout_b [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per configuration, word array plus a countdown of sweep edges left.
    logic [31:0] m_mem [2][16];
    int          m_busy [2];
    logic        e_va [2], e_vb [2], e_col [2], p_va [2], p_vb [2];
    logic [31:0] e_da [2], e_db [2], p_da [2], p_db [2];

    always #5 clk = ~clk;

    dp_ram_be_clr #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(DEP0), .RDW_MODE(0),
                    .OUT_REG(0), .INIT_VALUE(INIT)) u_dut0 (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy[0]),
        .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
        .dout_a(dout_a[0]), .dout_b(dout_b[0]), .valid_a(valid_a[0]), .valid_b(valid_b[0]),
        .collision(collision[0]));

    dp_ram_be_clr #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(DEP1), .RDW_MODE(1),
                    .OUT_REG(1), .INIT_VALUE(INIT)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy[1]),
        .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
        .dout_a(dout_a[1]), .dout_b(dout_b[1]), .valid_a(valid_a[1]), .valid_b(valid_b[1]),
        .collision(collision[1]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] we);
        merge = old;
        for (int i = 0; i < 4; i++)
            if (we[i]) merge[i*8 +: 8] = din[i*8 +: 8];
    endfunction

    task automatic model_edge(input int k);
        int          dep;
        bit          newdata, oreg, act, in_a, in_b, nva, nvb;
        logic [31:0] rd_a, rd_b;
        dep     = (k == 0) ? DEP0 : DEP1;
        newdata = (k == 1);
        oreg    = (k == 1);
        act     = !rst && m_busy[k] == 0 && !clear;
        in_a    = int'(addr_a) < dep;
        in_b    = int'(addr_b) < dep;
        rd_a    = in_a ? m_mem[k][addr_a] : 32'h0;
        rd_b    = in_b ? m_mem[k][addr_b] : 32'h0;
        if (newdata && in_a) rd_a = merge(rd_a, din_a, we_a);
        if (newdata && in_b) rd_b = merge(rd_b, din_b, we_b);
        e_col[k] = act && en_a && en_b && addr_a == addr_b && (we_a != 0 || we_b != 0);
        if (act && en_b && in_b) m_mem[k][addr_b] = merge(m_mem[k][addr_b], din_b, we_b);
        if (act && en_a && in_a) m_mem[k][addr_a] = merge(m_mem[k][addr_a], din_a, we_a);
        if (rst) m_busy[k] = dep;
        else if (m_busy[k] > 0) begin
            m_mem[k][dep - m_busy[k]] = INIT;
            m_busy[k]--;
        end else if (clear) m_busy[k] = dep;
        nva = act && en_a;
        nvb = act && en_b;
        if (rst) begin
            e_va[k] = 0; e_vb[k] = 0; e_da[k] = 0; e_db[k] = 0;
            p_va[k] = 0; p_vb[k] = 0; p_da[k] = 0; p_db[k] = 0;
        end else if (!oreg) begin
            e_va[k] = nva; e_vb[k] = nvb;
            if (nva) e_da[k] = rd_a;
            if (nvb) e_db[k] = rd_b;
        end else begin
            e_va[k] = p_va[k]; e_vb[k] = p_vb[k];
            if (p_va[k]) e_da[k] = p_da[k];
            if (p_vb[k]) e_db[k] = p_db[k];
            p_va[k] = nva; p_vb[k] = nvb;
            if (nva) p_da[k] = rd_a;
            if (nvb) p_db[k] = rd_b;
        end
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d_busy", k), 32'(busy[k]), 32'(m_busy[k] > 0));
            check($sformatf("d%0d_col", k), 32'(collision[k]), 32'(e_col[k]));
            check($sformatf("d%0d_va", k), 32'(valid_a[k]), 32'(e_va[k]));
            check($sformatf("d%0d_vb", k), 32'(valid_b[k]), 32'(e_vb[k]));
            check($sformatf("d%0d_da", k), dout_a[k], e_da[k]);
            check($sformatf("d%0d_db", k), dout_b[k], e_db[k]);
        end
    endtask

    task automatic idle();
        rst = 0; clear = 0; en_a = 0; en_b = 0; we_a = 0; we_b = 0;
    endtask

    task automatic rand_access(input bit on);
        en_a   = on && $urandom_range(0, 1) == 1;
        en_b   = on && $urandom_range(0, 1) == 1;
        addr_a = 4'($urandom);
        addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom);
        we_a   = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        we_b   = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        din_a  = $urandom;
        din_b  = $urandom;
    endtask

    task automatic wait_idle();
        idle();
        for (int c = 0; c < 64 && (busy[0] || busy[1]); c++) tick();
        check("idle_wait", 32'(busy[0] | busy[1]), 32'h0);
    endtask

    // Pulses rst, then counts busy cycles per configuration while poking accesses.
    task automatic count_busy(input int clear_at, output int n0, output int n1);
        idle();
        rst = 1;
        tick();
        rst = 0;
        n0 = int'(busy[0]);
        n1 = int'(busy[1]);
        for (int c = 0; c < 64 && (busy[0] || busy[1]); c++) begin
            rand_access(busy[1]);
            clear = (c == clear_at);
            tick();
            n0 += int'(busy[0]);
            n1 += int'(busy[1]);
        end
        idle();
    endtask

    task automatic read_sweep(input bit check_init);
        idle();
        for (int i = 0; i < 17; i++) begin
            en_a = (i < 16); en_b = (i < 16);
            addr_a = 4'(i); addr_b = 4'(15 - i);
            tick();
            if (check_init && i < 16) check("sweep_rd0", dout_a[0], INIT);
            if (check_init && i >= 1 && i - 1 < DEP1) check("sweep_rd1", dout_a[1], INIT);
        end
        idle();
        tick();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0;
            for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
        end
        idle();
        addr_a = 0; addr_b = 0; din_a = 0; din_b = 0;

        // Power-up sweep, fill with data, then reset sweep must restore INIT.
        count_busy(-1, n0, n1);
        check("sweep_len0", n0, DEP0);
        check("sweep_len1", n1, DEP1);
        wait_idle();
        for (int i = 0; i < 16; i++) begin
            en_a = 1; we_a = 4'hF; addr_a = 4'(i); din_a = $urandom;
            tick();
        end
        idle();
        count_busy(-1, n0, n1);
        check("rst_len0", n0, DEP0);
        check("rst_len1", n1, DEP1);
        wait_idle();
        read_sweep(1);

        // Byte enables on address 3.
        en_a = 1; addr_a = 3; we_a = 4'hF; din_a = 32'h11223344; tick();
        we_a = 4'b0101; din_a = 32'hAABBCCDD; tick();
        we_a = 4'h0; tick();
        check("be_rd0", dout_a[0], 32'h11BB33DD);
        idle(); tick();
        check("be_rd1", dout_a[1], 32'h11BB33DD);

        // Same-port read-during-write on address 5.
        en_a = 1; addr_a = 5; we_a = 4'hF; din_a = 32'h0; tick();
        din_a = 32'hDEADBEEF; tick();
        check("rdw_old0", dout_a[0], 32'h0);
        idle(); tick();
        check("rdw_new1", dout_a[1], 32'hDEADBEEF);

        // Both ports write address 7.
        en_a = 1; addr_a = 7; we_a = 4'b0001; din_a = 32'h000000FF;
        en_b = 1; addr_b = 7; we_b = 4'hF;    din_b = 32'h12345678;
        tick();
        check("col_hi0", 32'(collision[0]), 32'h1);
        check("col_hi1", 32'(collision[1]), 32'h1);
        idle(); tick();
        check("col_lo0", 32'(collision[0]), 32'h0);
        check("col_lo1", 32'(collision[1]), 32'h0);
        en_a = 1; addr_a = 7; tick();
        check("dual_rd0", dout_a[0], 32'h123456FF);
        idle(); tick();
        check("dual_rd1", dout_a[1], 32'h123456FF);

        // Clear request, reset at cnt=9, ignored clear while busy.
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy0", 32'(busy[0]), 32'h1);
        count_busy(3, n0, n1);
        check("mid_len0", n0, DEP0);
        check("mid_len1", n1, DEP1);
        wait_idle();

        // Out-of-range address 12 on the 10-word configuration.
        en_b = 1; addr_b = 12; we_b = 4'hF; din_b = 32'hCAFEF00D; tick();
        idle(); en_a = 1; addr_a = 12; tick();
        check("oor_inrange0", dout_a[0], 32'hCAFEF00D);
        idle(); tick();
        check("oor_valid1", 32'(valid_a[1]), 32'h1);
        check("oor_data1", dout_a[1], 32'h0);
        check("one_shot0", 32'(valid_a[0]), 32'h0);
        read_sweep(0);

        // Random traffic including clear requests and occasional resets.
        for (int c = 0; c < 600; c++) begin
            rand_access(1);
            clear = $urandom_range(0, 63) == 0;
            rst   = $urandom_range(0, 299) == 0;
            tick();
        end
        wait_idle();
        read_sweep(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
